// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: EX-stage request and HI/LO result bundle for the multiply/divide unit
interface hilo_mdu_if;
  logic        valid;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_req;
  logic        busy;
  modport master (output valid, funct, operand_1, operand_2, flush, input hi, lo, stall_req, busy);
  modport slave  (input valid, funct, operand_1, operand_2, flush, output hi, lo, stall_req, busy);
endinterface

// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO owner with single-cycle multiply/moves and a 32-step restoring divider
module hilo_mdu (
  input logic       clk,
  input logic       rst,
  hilo_mdu_if.slave bus
);
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B, F_MTHI = 6'h11, F_MTLO = 6'h13;
  typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, busy_q, busy_d;
  logic        start, is_sdiv, is_div, neg1, neg2, ge;
  logic [31:0] mag1, mag2, rem_n, quo_n;
  logic [32:0] sh;
  logic [63:0] prod_s, prod_u;
  // Operand conditioning, products and one restoring step (quotient bits shift into the dividend register)
  always_comb begin
    start   = bus.valid & ~bus.flush & (state_q == IDLE);
    is_sdiv = bus.funct == F_DIV;
    is_div  = is_sdiv | (bus.funct == F_DIVU);
    neg1    = is_sdiv & bus.operand_1[31];
    neg2    = is_sdiv & bus.operand_2[31];
    mag1    = neg1 ? -bus.operand_1 : bus.operand_1;
    mag2    = neg2 ? -bus.operand_2 : bus.operand_2;
    prod_s  = $signed({{32{bus.operand_1[31]}}, bus.operand_1}) * $signed({{32{bus.operand_2[31]}}, bus.operand_2});
    prod_u  = {32'b0, bus.operand_1} * {32'b0, bus.operand_2};
    sh      = {rem_q, dvd_q[31]};
    ge      = sh >= {1'b0, dvs_q};
    rem_n   = ge ? sh[31:0] - dvs_q : sh[31:0];
    quo_n   = {dvd_q[30:0], ge};
  end
  // Next-state, HI/LO update and divider sequencing; flush drops any pending divide write
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (start) begin
      if (bus.funct == F_MULT) {hi_d, lo_d} = prod_s;
      if (bus.funct == F_MULTU) {hi_d, lo_d} = prod_u;
      if (bus.funct == F_MTHI) hi_d = bus.operand_1;
      if (bus.funct == F_MTLO) lo_d = bus.operand_1;
      if (is_div && bus.operand_2 == 32'd0) begin
        hi_d    = bus.operand_1;
        lo_d    = '1;
        state_d = DONE;
      end else if (is_div) begin
        dvd_d   = mag1;
        dvs_d   = mag2;
        rem_d   = '0;
        qneg_d  = neg1 ^ neg2;
        rneg_d  = neg1;
        cnt_d   = '0;
        state_d = DIV_RUN;
      end
    end else if (state_q == DIV_RUN && bus.flush) begin
      state_d = IDLE;
    end else if (state_q == DIV_RUN) begin
      dvd_d = quo_n;
      rem_d = rem_n;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        lo_d    = qneg_q ? -quo_n : quo_n;
        hi_d    = rneg_q ? -rem_n : rem_n;
        state_d = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  // State and architectural register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
    end
  end
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy_q;
  assign bus.stall_req = (start & is_div) | ((state_q == DIV_RUN) & ~bus.flush);
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed vector table plus flush/reset sequences for hilo_mdu
module tb_hilo_mdu;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B, F_MTHI = 6'h11, F_MTLO = 6'h13;
  typedef struct {
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_stall;
    logic        exp_busy;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;
  vec_t vecs[12];
  vec_t last;
  hilo_mdu_if bus ();
  hilo_mdu dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask
  task automatic run_op(input vec_t v, input int idx);
    int n;
    logic busy_last;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.funct = v.funct;
    bus.operand_1 = v.op1;
    bus.operand_2 = v.op2;
    n = 0;
    #1;
    while (bus.stall_req && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    busy_last = bus.busy;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.funct = 6'h00;
    #1;
    chk($sformatf("v%0d hi", idx), bus.hi, v.exp_hi);
    chk($sformatf("v%0d lo", idx), bus.lo, v.exp_lo);
    chk($sformatf("v%0d stall_cycles", idx), 32'(n), 32'(v.exp_stall));
    chk($sformatf("v%0d busy_last", idx), {31'b0, busy_last}, {31'b0, v.exp_busy});
    chk($sformatf("v%0d busy_after", idx), {31'b0, bus.busy}, 32'd0);
  endtask
  initial begin
    vecs[0]  = '{F_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 0,  1'b0};
    vecs[1]  = '{F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 0,  1'b0};
    vecs[2]  = '{F_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 0,  1'b0};
    vecs[3]  = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b1};
    vecs[4]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1};
    vecs[5]  = '{F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33, 1'b1};
    vecs[6]  = '{F_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33, 1'b1};
    vecs[7]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1};
    vecs[8]  = '{F_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1,  1'b1};
    vecs[9]  = '{F_MTHI,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 0,  1'b0};
    vecs[10] = '{F_MTLO,  32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 0,  1'b0};
    vecs[11] = '{6'h20,   32'h00000001, 32'h00000002, 32'h12345678, 32'h9ABCDEF0, 0,  1'b0};
    last     = '{F_DIV,   32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003, 33, 1'b1};
    rst = 1'b1;
    bus.valid = 1'b0;
    bus.funct = 6'h00;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset stall", {31'b0, bus.stall_req}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) run_op(vecs[i], i);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.funct = F_DIV;
    bus.operand_1 = 32'd100;
    bus.operand_2 = 32'd3;
    repeat (10) @(negedge clk);
    chk("flush pre stall", {31'b0, bus.stall_req}, 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush stall", {31'b0, bus.stall_req}, 32'd0);
    @(negedge clk);
    chk("flush busy", {31'b0, bus.busy}, 32'd0);
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    chk("flush hi", bus.hi, 32'h12345678);
    chk("flush lo", bus.lo, 32'h9ABCDEF0);
    bus.funct = F_MULT;
    bus.operand_1 = 32'd2;
    bus.operand_2 = 32'd3;
    @(negedge clk);
    chk("novalid hi", bus.hi, 32'h12345678);
    chk("novalid lo", bus.lo, 32'h9ABCDEF0);
    chk("novalid stall", {31'b0, bus.stall_req}, 32'd0);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.funct = F_DIV;
    bus.operand_1 = 32'd100;
    bus.operand_2 = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.valid = 1'b0;
    #1;
    chk("midrst hi", bus.hi, 32'd0);
    chk("midrst lo", bus.lo, 32'd0);
    chk("midrst busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst stall", {31'b0, bus.stall_req}, 32'd0);
    run_op(last, 12);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
